// File: rtl/pong_pkg.sv
// Shared pong constants: screen geometry, field widths and rasterizer states.
// Imported by the rasterizer, screen drawer and location processors.
package pong_pkg;

  localparam int SCREEN_WIDTH  = 320;
  localparam int SCREEN_HEIGHT = 240;
  localparam int COORD_W       = 9;
  localparam int COLOR_W       = 3;
  localparam int SUM_W         = COORD_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DRAW = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/box_rasterizer_if.sv
// Box command handshake plus vga_adapter plot bus.
// slave: rasterizer side; master: command source / pixel sink side.
interface box_rasterizer_if;
  import pong_pkg::*;

  logic               s_valid;
  logic               s_ready;
  logic [COORD_W-1:0] in_box_x;
  logic [COORD_W-1:0] in_box_y;
  logic [COORD_W-1:0] in_box_w;
  logic [COORD_W-1:0] in_box_h;
  logic [COLOR_W-1:0] in_box_color;
  logic [8:0]         vga_x;
  logic [7:0]         vga_y;
  logic [COLOR_W-1:0] colour;
  logic               plot;
  logic               busy;
  logic               done;

  modport slave (
    input  s_valid, in_box_x, in_box_y,
    input  in_box_w, in_box_h, in_box_color,
    output s_ready, vga_x, vga_y, colour,
    output plot, busy, done
  );

  modport master (
    output s_valid, in_box_x, in_box_y,
    output in_box_w, in_box_h, in_box_color,
    input  s_ready, vga_x, vga_y, colour,
    input  plot, busy, done
  );

endinterface

// File: rtl/box_rasterizer_raster_counter.sv
// 2-D raster scan counter: cx inner, cy outer, last at (w-1, h-1).
// Ports: clock, reset, clr, en, w, h in; cx, cy, last out.
module raster_counter
  import pong_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               clr,
  input  logic               en,
  input  logic [COORD_W-1:0] w,
  input  logic [COORD_W-1:0] h,
  output logic [COORD_W-1:0] cx,
  output logic [COORD_W-1:0] cy,
  output logic               last
);

  logic [COORD_W-1:0] cx_q, cx_d;
  logic [COORD_W-1:0] cy_q, cy_d;
  logic               x_end;

  assign x_end = (cx_q == w - COORD_W'(1));
  assign last  = x_end && (cy_q == h - COORD_W'(1));
  assign cx    = cx_q;
  assign cy    = cy_q;

  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (clr) begin
      cx_d = '0;
      cy_d = '0;
    end else if (en) begin
      if (x_end) begin
        cx_d = '0;
        cy_d = cy_q + COORD_W'(1);
      end else begin
        cx_d = cx_q + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

endmodule

// File: rtl/box_rasterizer.sv
// Box rasterizer: accepts a box command, scans it one pixel per clock.
// Ports: clock, reset, bus (slave: command in, vga plot/busy/done out).
module box_rasterizer
  import pong_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  box_rasterizer_if.slave  bus
);

  logic [1:0]         state_q, state_d;
  logic [COORD_W-1:0] x0_q, x0_d;
  logic [COORD_W-1:0] y0_q, y0_d;
  logic [COORD_W-1:0] w_q, w_d;
  logic [COORD_W-1:0] h_q, h_d;
  logic [COLOR_W-1:0] col_q, col_d;

  logic               accept;
  logic               drawing;
  logic [COORD_W-1:0] cx, cy;
  logic               last;
  logic [SUM_W-1:0]   x_sum, y_sum;
  logic               visible;

  assign accept  = (state_q == ST_IDLE) && bus.s_valid;
  assign drawing = (state_q == ST_DRAW);

  raster_counter u_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (accept),
    .en    (drawing),
    .w     (w_q),
    .h     (h_q),
    .cx    (cx),
    .cy    (cy),
    .last  (last)
  );

  // One extra bit so positions past 511 are still clipped, not wrapped.
  assign x_sum   = {1'b0, x0_q} + {1'b0, cx};
  assign y_sum   = {1'b0, y0_q} + {1'b0, cy};
  assign visible = (x_sum < SUM_W'(SCREEN_WIDTH)) &&
                   (y_sum < SUM_W'(SCREEN_HEIGHT));

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    w_d     = w_q;
    h_d     = h_q;
    col_d   = col_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.s_valid) begin
          x0_d  = bus.in_box_x;
          y0_d  = bus.in_box_y;
          w_d   = bus.in_box_w;
          h_d   = bus.in_box_h;
          col_d = bus.in_box_color;
          if (bus.in_box_w == '0 || bus.in_box_h == '0)
            state_d = ST_DONE;
          else
            state_d = ST_DRAW;
        end
      end
      ST_DRAW: begin
        if (last)
          state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      w_q     <= w_d;
      h_q     <= h_d;
      col_q   <= col_d;
    end
  end

  assign bus.s_ready = (state_q == ST_IDLE);
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.plot    = drawing && visible;
  assign bus.vga_x   = drawing ? x_sum[8:0] : 9'd0;
  assign bus.vga_y   = drawing ? y_sum[7:0] : 8'd0;
  assign bus.colour  = drawing ? col_q : '0;

endmodule

// File: tb/tb_box_rasterizer.sv
// Self-checking bench for box_rasterizer.
// Scoreboard of expected pixels/done pulses, checked by a negedge monitor.
module tb_box_rasterizer;
  import pong_pkg::*;

  logic clock;
  logic reset;
  box_rasterizer_if bus ();

  box_rasterizer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int cyc;
    int x;
    int y;
    int c;
  } pix_t;

  pix_t pq[$];
  int   dq[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_plots = 0;
  int   last_x = -1;
  int   last_y = -1;

  always @(posedge clock) cyc <= cyc + 1;

  // Expected pixels of a box accepted at the edge after cycle n.
  function automatic void push_box(input int n, input int x, input int y,
                                   input int w, input int h, input int c,
                                   input int maxpix);
    pix_t e;
    int   k;
    for (int r = 0; r < h; r++) begin
      for (int q = 0; q < w; q++) begin
        k = r * w + q + 1;
        if ((maxpix < 0 || k <= maxpix) &&
            (x + q) < 320 && (y + r) < 240) begin
          e.cyc = n + k;
          e.x   = x + q;
          e.y   = (y + r) % 256;
          e.c   = c;
          pq.push_back(e);
        end
      end
    end
    if (maxpix < 0)
      dq.push_back((w == 0 || h == 0) ? n + 1 : n + w * h + 1);
  endfunction

  always @(negedge clock) begin
    pix_t e;
    bit   exp_d;
    if (bus.plot === 1'b1) begin
      n_plots++;
      last_x = int'(bus.vga_x);
      last_y = int'(bus.vga_y);
    end
    if (bus.plot === 1'b1 || (pq.size() > 0 && pq[0].cyc == cyc)) begin
      n_checks++;
      if (pq.size() == 0 || pq[0].cyc != cyc) begin
        n_fail++;
        $display("FAIL pixel cyc=%0d: plot=%b at (%0d,%0d) unexpected",
                 cyc, bus.plot, bus.vga_x, bus.vga_y);
      end else begin
        e = pq.pop_front();
        if (bus.plot !== 1'b1 || int'(bus.vga_x) != e.x ||
            int'(bus.vga_y) != e.y || int'(bus.colour) != e.c) begin
          n_fail++;
          $display("FAIL pixel cyc=%0d: got plot=%b (%0d,%0d) c=%0d want (%0d,%0d) c=%0d",
                   cyc, bus.plot, bus.vga_x, bus.vga_y, bus.colour,
                   e.x, e.y, e.c);
        end
      end
    end
    exp_d = (dq.size() > 0 && dq[0] == cyc);
    if (bus.done === 1'b1 || exp_d) begin
      n_checks++;
      if (bus.done !== exp_d) begin
        n_fail++;
        $display("FAIL done cyc=%0d: got %b want %b", cyc, bus.done, exp_d);
      end
      if (exp_d) void'(dq.pop_front());
    end
  end

  task automatic send(input int x, input int y, input int w, input int h,
                      input int c, input int maxpix, output int n);
    bus.in_box_x     = x[8:0];
    bus.in_box_y     = y[8:0];
    bus.in_box_w     = w[8:0];
    bus.in_box_h     = h[8:0];
    bus.in_box_color = c[2:0];
    bus.s_valid      = 1'b1;
    n = cyc;
    push_box(n, x, y, w, h, c, maxpix);
    @(negedge clock);
    bus.s_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_checks += 5;
    if (bus.s_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_ready: got %b want 1", bus.s_ready);
    end
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy);
    end
    if (bus.done !== 1'b0) begin
      n_fail++; $display("FAIL rst_done: got %b want 0", bus.done);
    end
    if (bus.plot !== 1'b0) begin
      n_fail++; $display("FAIL rst_plot: got %b want 0", bus.plot);
    end
    if (bus.vga_x !== 9'd0) begin
      n_fail++; $display("FAIL rst_vga_x: got %0d want 0", bus.vga_x);
    end
  endtask

  task automatic test_basic();
    int n;
    send(5, 7, 2, 2, 4, -1, n);
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_busy: got %b want 1", bus.busy);
    end
    repeat (4) @(negedge clock);
    n_checks++;
    if (cyc != n + 5 || bus.s_ready !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_ready: got %b want 0", bus.s_ready);
    end
    @(negedge clock);
    n_checks++;
    if (bus.s_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_ready: got %b want 1", bus.s_ready);
    end
  endtask

  task automatic test_zero();
    int n;
    send(20, 30, 0, 5, 7, -1, n);
    n_checks++;
    if (bus.done !== 1'b1 || bus.s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done: got done=%b ready=%b want 1/0",
               bus.done, bus.s_ready);
    end
    @(negedge clock);
    n_checks++;
    if (bus.s_ready !== 1'b1) begin
      n_fail++; $display("FAIL zero_ready: got %b want 1", bus.s_ready);
    end
  endtask

  task automatic test_clip();
    int n;
    send(318, 239, 4, 2, 2, -1, n);
    repeat (8) @(negedge clock);
    n_checks++;
    if (bus.done !== 1'b1) begin
      n_fail++; $display("FAIL clip_done: got %b want 1", bus.done);
    end
    @(negedge clock);
    n_checks++;
    if (bus.s_ready !== 1'b1) begin
      n_fail++; $display("FAIL clip_ready: got %b want 1", bus.s_ready);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    n = cyc;
    bus.in_box_x     = 9'd10;
    bus.in_box_y     = 9'd20;
    bus.in_box_w     = 9'd3;
    bus.in_box_h     = 9'd2;
    bus.in_box_color = 3'd1;
    bus.s_valid      = 1'b1;
    push_box(n, 10, 20, 3, 2, 1, -1);
    @(negedge clock);
    bus.in_box_x     = 9'd50;
    bus.in_box_y     = 9'd60;
    bus.in_box_w     = 9'd2;
    bus.in_box_h     = 9'd3;
    bus.in_box_color = 3'd6;
    push_box(n + 8, 50, 60, 2, 3, 6, -1);
    repeat (7) @(negedge clock);
    n_checks++;
    if (bus.s_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ready: got %b want 1", bus.s_ready);
    end
    @(negedge clock);
    bus.s_valid = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_accept: busy got %b want 1", bus.busy);
    end
    repeat (7) @(negedge clock);
    n_checks++;
    if (bus.s_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: ready=%b busy=%b want 1/0",
               bus.s_ready, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    send(0, 0, 10, 10, 5, 20, n);
    repeat (19) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_checks++;
    if (bus.plot !== 1'b0 || bus.s_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: plot=%b ready=%b busy=%b want 0/1/0",
               bus.plot, bus.s_ready, bus.busy);
    end
    repeat (90) @(negedge clock);
  endtask

  task automatic test_paddle();
    int n;
    n_plots = 0;
    send(310, 96, 10, 48, 3, -1, n);
    repeat (480) @(negedge clock);
    n_checks++;
    if (bus.done !== 1'b1) begin
      n_fail++; $display("FAIL paddle_done: got %b want 1", bus.done);
    end
    @(negedge clock);
    n_checks += 2;
    if (n_plots != 480) begin
      n_fail++; $display("FAIL paddle_count: got %0d want 480", n_plots);
    end
    if (last_x != 319 || last_y != 143) begin
      n_fail++;
      $display("FAIL paddle_last: got (%0d,%0d) want (319,143)",
               last_x, last_y);
    end
  endtask

  initial begin
    reset            = 1'b1;
    bus.s_valid      = 1'b0;
    bus.in_box_x     = '0;
    bus.in_box_y     = '0;
    bus.in_box_w     = '0;
    bus.in_box_h     = '0;
    bus.in_box_color = '0;
    test_reset();
    test_basic();
    test_zero();
    test_clip();
    test_back_to_back();
    test_reset_mid();
    test_paddle();
    repeat (3) @(negedge clock);
    n_checks++;
    if (pq.size() != 0 || dq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d pixels %0d dones left want 0",
               pq.size(), dq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
